// File: rtl/data_memory_responder.sv
// data_memory_responder
//   Target end of the core's load/store interface. Accepts one request at a
//   time, optionally waits WAIT_CYCLES cycles, performs an RV32I byte/half/word
//   store or sign/zero-extended load on a 2^ADDR_WIDTH x 32-bit memory, and
//   returns read data plus an error flag.
//
//   Optional feature macro: DMEM_ERR_CHECK_EN
//     defined   : misaligned half/word accesses and addresses beyond the
//                 memory size fault (rsp_err=1, no write, rsp_rdata=0).
//     undefined : no alignment/range checks; upper address bits ignored
//                 (address wraps), half lane from addr[1], word ignores
//                 addr[1:0]. Only an illegal funct3 faults.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. req_* are sampled only on that edge. rsp_valid stays high and
// rsp_rdata/rsp_err stay stable until the response handshake.
//
// Ports
//   clk, reset      : clock (rising edge), asynchronous active-low reset
//   req_valid/ready : request channel (ready is high only in IDLE)
//   req_write       : 1 = store, 0 = load
//   req_funct3      : RV32I load/store funct3
//   req_addr        : byte address
//   req_wdata       : right-aligned store data
//   rsp_valid/ready : response channel
//   rsp_rdata       : load result (0 for stores and faults)
//   rsp_err         : request faulted
//   dbg_state       : current FSM state (0 IDLE, 1 WAIT, 2 RESP)
module data_memory_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam int         DEPTH  = 1 << ADDR_WIDTH;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_go_resp;
  logic                  w_from_in;
  logic                  w_a_write;
  logic [2:0]            w_a_funct3;
  logic [31:0]           w_a_addr;
  logic [31:0]           w_a_wdata;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [1:0]            w_lane;
  logic [31:0]           w_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic                  w_err;
  logic [3:0]            w_be;
  logic [31:0]           w_wrep;
  logic [31:0]           w_load;

  assign w_accept  = (r_state == S_IDLE) && req_valid;
  // The access happens on the edge that enters RESP: straight from IDLE when
  // there are no wait states, otherwise at the end of WAIT.
  assign w_go_resp = (w_accept && (WAIT_CYCLES == 0)) ||
                     ((r_state == S_WAIT) && (r_cnt == 4'd1));

  // With zero wait states the access uses the live request, otherwise the
  // request latched at acceptance.
  assign w_from_in  = (r_state == S_IDLE);
  assign w_a_write  = w_from_in ? req_write  : r_write;
  assign w_a_funct3 = w_from_in ? req_funct3 : r_funct3;
  assign w_a_addr   = w_from_in ? req_addr   : r_addr;
  assign w_a_wdata  = w_from_in ? req_wdata  : r_wdata;

  assign w_idx  = w_a_addr[ADDR_WIDTH+1:2];
  assign w_lane = w_a_addr[1:0];
  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_lane, 3'b000} +: 8];
  assign w_half = w_a_addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_err  = 1'b0;
    w_be   = 4'b0000;
    w_wrep = 32'd0;
    w_load = 32'd0;
    if (w_a_write) begin
      case (w_a_funct3)
        3'b000: begin
          w_be   = 4'b0001 << w_lane;
          w_wrep = {4{w_a_wdata[7:0]}};
        end
        3'b001: begin
          w_be   = w_a_addr[1] ? 4'b1100 : 4'b0011;
          w_wrep = {2{w_a_wdata[15:0]}};
        end
        3'b010: begin
          w_be   = 4'b1111;
          w_wrep = w_a_wdata;
        end
        default: w_err = 1'b1;
      endcase
    end else begin
      case (w_a_funct3)
        3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
        3'b001:  w_load = {{16{w_half[15]}}, w_half};
        3'b010:  w_load = w_word;
        3'b100:  w_load = {24'd0, w_byte};
        3'b101:  w_load = {16'd0, w_half};
        default: w_err  = 1'b1;
      endcase
    end
`ifdef DMEM_ERR_CHECK_EN
    if ((w_a_funct3[1:0] == 2'b01) && w_a_addr[0])
      w_err = 1'b1;
    if ((w_a_funct3[1:0] == 2'b10) && (w_a_addr[1:0] != 2'b00))
      w_err = 1'b1;
    if ((w_a_addr >> (ADDR_WIDTH + 2)) != 32'd0)
      w_err = 1'b1;
`endif
    // A fault suppresses both the write and the read data.
    if (w_err) begin
      w_be   = 4'b0000;
      w_load = 32'd0;
    end
  end

  // Memory has no reset; the write is gated by reset so an access cannot
  // commit while reset is held.
  always_ff @(posedge clk) begin
    if (w_go_resp && reset) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wrep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_write  <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write  <= req_write;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_cnt    <= 4'(WAIT_CYCLES);
            r_state  <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_go_resp) begin
        r_rdata <= w_load;
        r_err   <= w_err;
      end
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: three instances (WAIT_CYCLES 0, 1, 3)
// share the request payload and rsp_ready; each has its own req_valid.
// Index 0 -> WAIT_CYCLES=0, 1 -> WAIT_CYCLES=1, 2 -> WAIT_CYCLES=3.
module tb_data_memory_responder;

`ifdef DMEM_ERR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             rst3_n;
  logic [2:0]       v;
  logic [2:0]       rr;
  logic [2:0]       rv;
  logic [2:0]       er;
  logic [2:0][31:0] rd;
  logic [2:0][1:0]  st;
  logic             wr;
  logic [2:0]       f3;
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic             rsp_ready;

  int total = 0;
  int bad   = 0;
  int wc [3] = '{0, 1, 3};
  vec_t vt[$];
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  data_memory_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(rst_n), .req_valid(v[0]), .req_ready(rr[0]),
    .req_write(wr), .req_funct3(f3), .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_rdata(rd[0]),
    .rsp_err(er[0]), .dbg_state(st[0]));

  data_memory_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset(rst_n), .req_valid(v[1]), .req_ready(rr[1]),
    .req_write(wr), .req_funct3(f3), .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_rdata(rd[1]),
    .rsp_err(er[1]), .dbg_state(st[1]));

  data_memory_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(rst3_n), .req_valid(v[2]), .req_ready(rr[2]),
    .req_write(wr), .req_funct3(f3), .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(rv[2]), .rsp_ready(rsp_ready), .rsp_rdata(rd[2]),
    .rsp_err(er[2]), .dbg_state(st[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic w, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] er_d, input logic e);
    vec_t x;
    x.wr = w; x.f3 = f; x.addr = a; x.wdata = d; x.exp_rd = er_d; x.exp_err = e;
    vt.push_back(x);
  endtask

  // One full transaction on instance d with rsp_ready high. Returns the
  // response and the number of edges from acceptance to rsp_valid.
  task automatic txn(input int d, input logic w, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] dat,
                     output logic [31:0] o_rd, output logic o_err, output int lat);
    @(negedge clk);
    rsp_ready = 1'b1;
    wr = w; f3 = f; addr = a; wdata = dat;
    v[d] = 1'b1;
    @(posedge clk); #1;
    v[d] = 1'b0;
    // Payload changes after acceptance must be ignored.
    wr = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
    addr = $urandom; wdata = $urandom;
    lat = 0;
    while (!rv[d] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    o_rd  = rd[d];
    o_err = er[d];
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] g_rd;
    logic        g_err;
    int          lat;
    logic [32:0] e;

    v = 3'b000; wr = 1'b0; f3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    rsp_ready = 1'b1;
    rst_n = 1'b0; rst3_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_req_ready[%0d]", i), 32'(rr[i]), 32'd1);
      chk($sformatf("reset_rsp_valid[%0d]", i), 32'(rv[i]), 32'd0);
      chk($sformatf("reset_rdata[%0d]", i), rd[i], 32'd0);
      chk($sformatf("reset_err[%0d]", i), 32'(er[i]), 32'd0);
      chk($sformatf("reset_state[%0d]", i), 32'(st[i]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1; rst3_n = 1'b1;

    // ---------------- table-driven vectors on WAIT_CYCLES=1 ----------------
    add(1, 3'b010, 32'h010, 32'hDEADBEEF, 32'h0, 0);
    add(0, 3'b010, 32'h010, 32'h0,        32'hDEADBEEF, 0);
    add(1, 3'b000, 32'h013, 32'h00000080, 32'h0, 0);
    add(0, 3'b000, 32'h013, 32'h0,        32'hFFFFFF80, 0);
    add(0, 3'b100, 32'h013, 32'h0,        32'h00000080, 0);
    add(0, 3'b010, 32'h010, 32'h0,        32'h80ADBEEF, 0);
    add(1, 3'b001, 32'h012, 32'h00001234, 32'h0, 0);
    add(0, 3'b101, 32'h012, 32'h0,        32'h00001234, 0);
    add(0, 3'b010, 32'h010, 32'h0,        32'h1234BEEF, 0);
    add(0, 3'b001, 32'h010, 32'h0,        32'hFFFFBEEF, 0);
    add(1, 3'b000, 32'h011, 32'hFFFFFFA5, 32'h0, 0);
    add(0, 3'b010, 32'h010, 32'h0,        32'h1234A5EF, 0);
    add(0, 3'b000, 32'h012, 32'h0,        32'h00000034, 0);
    add(0, 3'b100, 32'h011, 32'h0,        32'h000000A5, 0);
    add(0, 3'b000, 32'h011, 32'h0,        32'hFFFFFFA5, 0);
    add(0, 3'b101, 32'h013, 32'h0,        CHK ? 32'h0 : 32'h00001234, CHK);
    add(0, 3'b011, 32'h010, 32'h0,        32'h0, 1);
    add(0, 3'b110, 32'h010, 32'h0,        32'h0, 1);
    add(0, 3'b111, 32'h010, 32'h0,        32'h0, 1);
    add(1, 3'b011, 32'h010, 32'hFFFFFFFF, 32'h0, 1);
    add(1, 3'b100, 32'h010, 32'hFFFFFFFF, 32'h0, 1);
    add(0, 3'b010, 32'h010, 32'h0,        32'h1234A5EF, 0);
    add(0, 3'b010, 32'h011, 32'h0,        CHK ? 32'h0 : 32'h1234A5EF, CHK);
    add(1, 3'b010, 32'h000, 32'hCAFEF00D, 32'h0, 0);
    add(1, 3'b010, 32'h1000, 32'h11111111, 32'h0, CHK);
    add(0, 3'b010, 32'h000, 32'h0,        CHK ? 32'hCAFEF00D : 32'h11111111, 0);

    foreach (vt[i]) begin
      exp_q.push_back({vt[i].exp_err, vt[i].exp_rd});
      txn(1, vt[i].wr, vt[i].f3, vt[i].addr, vt[i].wdata, g_rd, g_err, lat);
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_rdata", i), g_rd, e[31:0]);
      chk($sformatf("vec%0d_err", i), 32'(g_err), 32'(e[32]));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(wc[1]));
    end

    // ---------------- back-pressure on WAIT_CYCLES=1 ----------------
    @(negedge clk);
    rsp_ready = 1'b0;
    wr = 1'b0; f3 = 3'b010; addr = 32'h010; wdata = 32'h0;
    v[1] = 1'b1;
    @(posedge clk); #1;
    // A competing store is offered throughout; it must not be accepted.
    wr = 1'b1; addr = 32'h010; wdata = 32'hBADBAD00;
    lat = 0;
    while (!rv[1] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_latency", 32'(lat), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_valid[%0d]", i), 32'(rv[1]), 32'd1);
      chk($sformatf("bp_rdata[%0d]", i), rd[1], 32'h1234A5EF);
      chk($sformatf("bp_req_ready[%0d]", i), 32'(rr[1]), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    v[1] = 1'b0;
    chk("bp_release_valid", 32'(rv[1]), 32'd0);
    chk("bp_release_req_ready", 32'(rr[1]), 32'd1);
    txn(1, 0, 3'b010, 32'h010, 32'h0, g_rd, g_err, lat);
    chk("bp_mem_unchanged", g_rd, 32'h1234A5EF);

    // ---------------- reset during WAIT on WAIT_CYCLES=3 ----------------
    txn(2, 1, 3'b010, 32'h020, 32'h12345678, g_rd, g_err, lat);
    chk("w3_store_latency", 32'(lat), 32'd3);
    txn(2, 0, 3'b010, 32'h020, 32'h0, g_rd, g_err, lat);
    chk("w3_load_rdata", g_rd, 32'h12345678);
    @(negedge clk);
    wr = 1'b1; f3 = 3'b010; addr = 32'h020; wdata = 32'h00000055;
    v[2] = 1'b1;
    @(posedge clk); #1;
    v[2] = 1'b0;
    chk("w3_in_wait", 32'(st[2]), 32'd1);
    @(posedge clk); #1;
    rst3_n = 1'b0;
    #1;
    chk("w3_rst_req_ready", 32'(rr[2]), 32'd1);
    chk("w3_rst_valid", 32'(rv[2]), 32'd0);
    chk("w3_rst_rdata", rd[2], 32'd0);
    chk("w3_rst_err", 32'(er[2]), 32'd0);
    chk("w3_rst_state", 32'(st[2]), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst3_n = 1'b1;
    txn(2, 0, 3'b010, 32'h020, 32'h0, g_rd, g_err, lat);
    chk("w3_dropped_write", g_rd, 32'h12345678);

    // ---------------- WAIT_CYCLES=0 back-to-back ----------------
    txn(0, 1, 3'b010, 32'h040, 32'h0BADF00D, g_rd, g_err, lat);
    chk("w0_store_latency", 32'(lat), 32'd0);
    @(negedge clk);
    rsp_ready = 1'b1;
    wr = 1'b0; f3 = 3'b010; addr = 32'h040; wdata = 32'h0;
    v[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk($sformatf("w0_valid_edge%0d", i), 32'(rv[0]), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) chk($sformatf("w0_rdata_edge%0d", i), rd[0], 32'h0BADF00D);
    end
    v[0] = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Data-memory responder for the RISC-V microcontroller: the target end of the core's load/store interface. Accepts one request at a time over a valid/ready channel and performs byte/half/word stores or sign/zero-extended loads per RV32I funct3. Inserts a configurable number of wait states and returns a response with read data and error status over a second valid/ready channel.

## Interface
- `ADDR_WIDTH`, 10: word-address bits; memory is 2^ADDR_WIDTH × 32-bit words (default 4 KiB).
- `WAIT_CYCLES`, 1: wait states between request acceptance and memory access, legal range 0–15.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I load/store funct3.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  initiator accepts response.
- `rsp_rdata`  out  32  load result; 0 for stores and errors.
- `rsp_err`  out  1  request faulted.

## Operation
- FSM: IDLE → WAIT (only if WAIT_CYCLES>0) → RESP → IDLE.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, latch write, funct3, addr, wdata; load wait counter with WAIT_CYCLES; go to WAIT, or RESP if WAIT_CYCLES=0.
- WAIT: `req_ready`=0. Decrement counter each cycle; at 1, go to RESP.
- Access is committed on the edge entering RESP; memory write and `rsp_rdata`/`rsp_err` registers update on that edge.
- RESP: `rsp_valid`=1; `rsp_rdata`/`rsp_err` held stable until `rsp_valid && rsp_ready`, then IDLE. Back-pressure is unlimited.
- funct3 for loads: 000 LB (sign-ext byte), 001 LH (sign-ext half), 010 LW, 100 LBU, 101 LHU. For stores: 000 SB, 001 SH, 010 SW.
- Byte lane selected by addr[1:0], half lane by addr[1]. Stores modify only the addressed bytes; other bytes unchanged.
- Illegal funct3 (load: 011, 110, 111; store: anything except 000/001/010) → `rsp_err`=1, no memory change, `rsp_rdata`=0.
- Memory contents are not cleared by reset.

## Timing
- Reset (asynchronous assertion, synchronous deassertion): state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, wait counter 0.
- Reset mid-operation: a request in WAIT is dropped with no memory write. A request already in RESP has committed its write; its response is discarded.
- Latency: request accepted on edge E → `rsp_valid` high in the cycle after edge E+WAIT_CYCLES.
- Throughput: one request per WAIT_CYCLES+2 cycles with `rsp_ready` tied high. No acceptance during WAIT or RESP, even on the response-handshake cycle.
- `req_*` inputs are sampled only on the acceptance edge; later changes are ignored.

## Configuration
- `DMEM_ERR_CHECK_EN` defined: halfword access with addr[0]=1, word access with addr[1:0]≠0, and any addr[31:ADDR_WIDTH+2]≠0 each give `rsp_err`=1, no memory change, `rsp_rdata`=0.
- Not defined: no alignment or range checks. Upper address bits are ignored, so the address wraps modulo memory size. Halfword lane uses addr[1] and word ignores addr[1:0], forcing natural alignment. `rsp_err` is set only by illegal funct3.

## Test plan
- Reset, WAIT_CYCLES=1: SW 0xDEADBEEF at 0x010 accepted on edge E → `rsp_valid` in cycle after E+1, `rsp_err`=0. LW 0x010 → `rsp_rdata`=0xDEADBEEF.
- Byte/half lanes: SB 0x80 at 0x013, then LB 0x013 → 0xFFFFFF80. LBU 0x013 → 0x00000080. LW 0x010 → 0x80ADBEEF. SH 0x1234 at 0x012, then LHU 0x012 → 0x00001234.
- Back-pressure: hold `rsp_ready`=0 for 5 cycles → `rsp_valid`, `rsp_rdata` stable and `req_ready`=0 throughout. Raise `rsp_ready` → IDLE next cycle, `req_ready`=1.
- Errors with `DMEM_ERR_CHECK_EN`: LW 0x011 → `rsp_err`=1, `rsp_rdata`=0. SW to 0x1000 (ADDR_WIDTH=10) → `rsp_err`=1 and memory unchanged. Load funct3=011 → `rsp_err`=1. Without the macro: LW 0x011 returns word at 0x010, `rsp_err`=0.
- Reset during WAIT (WAIT_CYCLES=3): SW 0x55 at 0x020, assert `reset` one cycle after acceptance → outputs at reset values immediately. After release, LW 0x020 returns the prior contents.
- WAIT_CYCLES=0: back-to-back LW with `rsp_ready`=1 → `rsp_valid` in the cycle after acceptance, one request every 2 cycles.
